// File: rtl/riswitch_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riswitch_mem_pkg
//  Description : Shared memory-op encodings, the LSU state type and an
//                access-size helper for the load/store control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package riswitch_mem_pkg;

    // Load encodings (as presented on reqOp and memOp)
    localparam logic [2:0] M_LB  = 3'd0;
    localparam logic [2:0] M_LH  = 3'd1;
    localparam logic [2:0] M_LW  = 3'd2;
    localparam logic [2:0] M_LBU = 3'd4;
    localparam logic [2:0] M_LHU = 3'd5;

    // Store encodings reuse the load size codes
    localparam logic [2:0] M_SB  = 3'd0;
    localparam logic [2:0] M_SH  = 3'd1;
    localparam logic [2:0] M_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Access size in bytes; 0 marks an illegal op code
    function automatic logic [2:0] op_size(input logic [2:0] op);
        logic [2:0] sz;
        case (op)
            M_LB, M_LBU: sz = 3'd1;
            M_LH, M_LHU: sz = 3'd2;
            M_LW:        sz = 3'd4;
            default:     sz = 3'd0;
        endcase
        return sz;
    endfunction

endpackage : riswitch_mem_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Merges one load byte into the little-endian assembly buffer
//                and sign/zero-extends the merged word per the load op.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_load_align
    import riswitch_mem_pkg::*;
(
    input  logic [31:0] buf_i,     // bytes collected by earlier beats
    input  logic [7:0]  byte_i,    // byte returned by the current beat
    input  logic [1:0]  slot_i,    // byte lane the current beat fills
    input  logic [2:0]  op_i,      // original load op
    output logic [31:0] merged_o,  // buffer with the current byte inserted
    output logic [31:0] data_o     // merged word, extended per op_i
);

    // Drop the new byte into its lane of the assembly buffer
    always_comb begin
        merged_o = buf_i;
        merged_o[{slot_i, 3'b000} +: 8] = byte_i;
    end

    // Extend the assembled value to the full word width
    always_comb begin
        case (op_i)
            M_LB:    data_o = {{24{merged_o[7]}}, merged_o[7:0]};
            M_LBU:   data_o = {24'h000000, merged_o[7:0]};
            M_LH:    data_o = {{16{merged_o[15]}}, merged_o[15:0]};
            M_LHU:   data_o = {16'h0000, merged_o[15:0]};
            default: data_o = merged_o;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store control unit in front of the data memory. Takes
//                one request at a time, drives the memory port from
//                registered state, and returns load data / store completion.
//                Optional macro LSU_MISALIGN_SPLIT_EN: misaligned accesses are
//                split into byte beats instead of being faulted.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl
    import riswitch_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,   // only 32 is supported
    parameter int RD_LAT = 1     // 1..4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    input  logic [2:0]        reqOp,
    input  logic              reqWe,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspData,
    output logic              rspErr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDin,
    output logic [2:0]        memOp,
    output logic              memWe,
    input  logic [DATA_W-1:0] memDout
);

    lsu_state_t        state_q;
    lsu_state_t        state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        op_q;
    logic              we_q;
    logic              split_q;      // access is being serialised into bytes
    logic [1:0]        beat_q;       // current beat index
    logic [1:0]        last_beat_q;  // beat count minus one
    logic [1:0]        lat_q;        // read-latency counter within WAIT
    logic [DATA_W-1:0] buf_q;        // split-load byte assembly buffer
    logic [DATA_W-1:0] rspData_q;
    logic              rspErr_q;

    logic [2:0]        w_size;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_err;
    logic              w_split;
    logic              w_last_beat;
    logic              w_wait_done;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_aligned;

    // Request classification, evaluated on the incoming request in IDLE
    assign w_size       = op_size(reqOp);
    assign w_illegal    = (w_size == 3'd0);
    assign w_misaligned = ((w_size == 3'd2) && reqAddr[0]) ||
                          ((w_size == 3'd4) && (reqAddr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_err   = w_illegal;
    assign w_split = w_misaligned;
`else
    assign w_err   = w_illegal || w_misaligned;
    assign w_split = 1'b0;
`endif

    assign w_last_beat = (beat_q == last_beat_q);
    assign w_wait_done = (lat_q == 2'(RD_LAT - 1));
    // Byte-beat address wraps naturally at the top of the address space
    assign w_beat_addr = addr_q + ADDR_W'(beat_q);

    assign rspData = rspData_q;
    assign rspErr  = rspErr_q;

    lsu_load_align u_align (
        .buf_i    (buf_q),
        .byte_i   (memDout[7:0]),
        .slot_i   (beat_q),
        .op_i     (op_q),
        .merged_o (w_merged),
        .data_o   (w_aligned)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    state_d = w_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!we_q) begin
                    state_d = WAIT;
                end else if (w_last_beat) begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    state_d = w_last_beat ? RESP : ISSUE;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and memory-port outputs, decoded from registered state only
    always_comb begin
        reqReady = 1'b0;
        rspValid = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memDin   = '0;
        memOp    = 3'd0;
        case (state_q)
            IDLE: begin
                reqReady = 1'b1;
            end
            ISSUE, WAIT: begin
                // Address and op are held through WAIT for the memory read
                memAddr = split_q ? w_beat_addr : addr_q;
                memOp   = split_q ? (we_q ? M_SB : M_LBU) : op_q;
                if ((state_q == ISSUE) && we_q) begin
                    memWe  = 1'b1;
                    memDin = split_q ? (wdata_q >> {beat_q, 3'b000}) : wdata_q;
                end
            end
            RESP: begin
                rspValid = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch, beat/latency counters and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= 3'd0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            beat_q      <= 2'd0;
            last_beat_q <= 2'd0;
            lat_q       <= 2'd0;
            buf_q       <= '0;
            rspData_q   <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        addr_q      <= reqAddr;
                        wdata_q     <= reqWdata;
                        op_q        <= reqOp;
                        we_q        <= reqWe;
                        split_q     <= w_split;
                        beat_q      <= 2'd0;
                        last_beat_q <= w_split ? 2'(w_size - 3'd1) : 2'd0;
                        lat_q       <= 2'd0;
                        buf_q       <= '0;
                        rspData_q   <= '0;
                        rspErr_q    <= w_err;
                    end
                end
                ISSUE: begin
                    lat_q <= 2'd0;
                    if (we_q && !w_last_beat) begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                WAIT: begin
                    if (!w_wait_done) begin
                        lat_q <= lat_q + 2'd1;
                    end else begin
                        buf_q <= w_merged;
                        if (w_last_beat) begin
                            // Aligned reads arrive already extended by the memory
                            rspData_q <= split_q ? w_aligned : memDout;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : lsu_ctrl
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Directed, table-driven bench for lsu_ctrl with a byte-wide
//                memory model (read latency 1). Expectations follow the
//                LSU_MISALIGN_SPLIT_EN setting of the build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqOp;
    logic        reqWe;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspErr;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic [2:0]  memOp;
    logic        memWe;
    logic [31:0] memDout;

    int n_chk = 0;
    int n_err = 0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqAddr  (reqAddr),
        .reqWdata (reqWdata),
        .reqOp    (reqOp),
        .reqWe    (reqWe),
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspData  (rspData),
        .rspErr   (rspErr),
        .memAddr  (memAddr),
        .memDin   (memDin),
        .memOp    (memOp),
        .memWe    (memWe),
        .memDout  (memDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0]  mem [0:1023];
    logic        mem_clr;
    logic        pk_req;
    logic [31:0] pk_addr;
    logic [31:0] pk_data;

    function automatic logic [9:0] idx(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + 32'(k);
        return s[9:0];
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] w;
        logic [31:0] r;
        w = {mem[idx(a, 3)], mem[idx(a, 2)], mem[idx(a, 1)], mem[idx(a, 0)]};
        case (op)
            3'd0:    r = {{24{w[7]}}, w[7:0]};
            3'd1:    r = {{16{w[15]}}, w[15:0]};
            3'd4:    r = {24'h0, w[7:0]};
            3'd5:    r = {16'h0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] peek(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mem[idx(a, k)];
        return r;
    endfunction

    always @(posedge clk) begin
        memDout <= rd(memAddr, memOp);
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            if (memWe) begin
                for (int k = 0; k < ((memOp == 3'd0) ? 1 : (memOp == 3'd1) ? 2 : 4); k++)
                    mem[idx(memAddr, k)] <= memDin[8*k +: 8];
            end
            if (pk_req) begin
                for (int k = 0; k < 4; k++) mem[idx(pk_addr, k)] <= pk_data[8*k +: 8];
            end
        end
    end

    // Write monitor
    int          we_cnt = 0;
    logic [31:0] last_waddr;
    logic [2:0]  last_wop;
    always @(negedge clk) begin
        if (memWe) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= memAddr;
            last_wop   <= memOp;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke32(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_req  = 1'b1;
        pk_addr = a;
        pk_data = d;
        @(posedge clk);
        #1 pk_req = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pl;
        logic [31:0] pl_data;      // preloaded at addr
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_wr;
        int          exp_lat;
        int          chk_n;        // bytes at addr to compare after the access
        logic [31:0] chk_val;
        logic [31:0] exp_waddr;    // last write address/op when exp_wr > 0
        logic [2:0]  exp_wop;
    } vec_t;

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic pl, input logic [31:0] pl_data,
                                input logic [31:0] exp_data, input logic exp_err,
                                input int exp_wr, input int exp_lat, input int chk_n,
                                input logic [31:0] chk_val, input logic [31:0] exp_waddr,
                                input logic [2:0] exp_wop);
        vec_t v;
        v.name = name; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.pl = pl; v.pl_data = pl_data; v.exp_data = exp_data; v.exp_err = exp_err;
        v.exp_wr = exp_wr; v.exp_lat = exp_lat; v.chk_n = chk_n; v.chk_val = chk_val;
        v.exp_waddr = exp_waddr; v.exp_wop = exp_wop;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        int w0;
        if (v.pl) poke32(v.addr, v.pl_data);
        @(negedge clk);
        reqValid = 1'b1;
        reqAddr  = v.addr;
        reqWdata = v.wdata;
        reqOp    = v.op;
        reqWe    = v.we;
        rspReady = 1'b1;
        w0       = we_cnt;
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid && lat < 64);
        if (!rspValid) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: got no response expected response", v.name);
            return;
        end
        chk({v.name, " data"}, rspData, v.exp_data);
        chk({v.name, " err"}, 32'(rspErr), 32'(v.exp_err));
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " writes"}, 32'(we_cnt - w0), 32'(v.exp_wr));
        if (v.exp_wr > 0) begin
            chk({v.name, " waddr"}, last_waddr, v.exp_waddr);
            chk({v.name, " wop"}, 32'(last_wop), 32'(v.exp_wop));
        end
        @(posedge clk);
        #1;
        if (v.chk_n > 0) chk({v.name, " mem"}, peek(v.addr, v.chk_n), v.chk_val);
    endtask

    vec_t vecs[16];

    initial begin
        int lat;
        logic [31:0] rst_addr;
        logic [31:0] rst_maddr;
        int          rst_edges;

        rst = 1'b1; mem_clr = 1'b1; pk_req = 1'b0; pk_addr = 0; pk_data = 0;
        reqValid = 1'b0; reqAddr = 0; reqWdata = 0; reqOp = 0; reqWe = 0; rspReady = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst reqReady", 32'(reqReady), 32'd1);
        chk("rst rspValid", 32'(rspValid), 32'd0);
        chk("rst memWe",    32'(memWe),    32'd0);
        chk("rst rspData",  rspData,       32'd0);
        chk("rst rspErr",   32'(rspErr),   32'd0);
        chk("rst memAddr",  memAddr,       32'd0);
        chk("rst memDin",   memDin,        32'd0);
        chk("rst memOp",    32'(memOp),    32'd0);
        rst = 1'b0; mem_clr = 1'b0;

        //           name        we  op    addr          wdata         pl  pl_data       exp_data                     err     wr          lat          chk  chk_val                      waddr                 wop
        vecs[0]  = mk("lw_al",   0, 3'd2, 32'h100,      0,            1, 32'hDEADBEEF, 32'hDEADBEEF,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[1]  = mk("sh_al",   1, 3'd1, 32'h102,      32'h1234,     0, 0,            0,                           0,      1,          2,           2,   32'h1234,                    32'h102,              3'd1);
        vecs[2]  = mk("lw_mis",  0, 3'd2, 32'h103,      0,            1, 32'h44332211, EN ? 32'h44332211 : 32'h0,   !EN,    0,          EN ? 9 : 1,  0,   0,                           0,                    0);
        vecs[3]  = mk("lh_mis",  0, 3'd1, 32'h0FF,      0,            1, 32'h0000FF80, EN ? 32'hFFFFFF80 : 32'h0,   !EN,    0,          EN ? 5 : 1,  0,   0,                           0,                    0);
        vecs[4]  = mk("lhu_mis", 0, 3'd5, 32'h0FF,      0,            0, 0,            EN ? 32'h0000FF80 : 32'h0,   !EN,    0,          EN ? 5 : 1,  0,   0,                           0,                    0);
        vecs[5]  = mk("sw_mis",  1, 3'd2, 32'h101,      32'hCAFEF00D, 0, 0,            0,                           !EN,    EN ? 4 : 0, EN ? 5 : 1,  4,   EN ? 32'hCAFEF00D : 32'h22110000, 32'h104,     3'd0);
        vecs[6]  = mk("op3",     0, 3'd3, 32'h100,      0,            0, 0,            0,                           1,      0,          1,           0,   0,                           0,                    0);
        vecs[7]  = mk("op6_st",  1, 3'd6, 32'h200,      32'hFFFFFFFF, 0, 0,            0,                           1,      0,          1,           0,   0,                           0,                    0);
        vecs[8]  = mk("lb",      0, 3'd0, 32'h200,      0,            1, 32'h800100F5, 32'hFFFFFFF5,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[9]  = mk("lbu",     0, 3'd4, 32'h200,      0,            0, 0,            32'h000000F5,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[10] = mk("lh",      0, 3'd1, 32'h202,      0,            0, 0,            32'hFFFF8001,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[11] = mk("lhu",     0, 3'd5, 32'h202,      0,            0, 0,            32'h00008001,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[12] = mk("lb_odd",  0, 3'd0, 32'h203,      0,            0, 0,            32'hFFFFFF80,                0,      0,          3,           0,   0,                           0,                    0);
        vecs[13] = mk("lw_wrap", 0, 3'd2, 32'hFFFFFFFE, 0,            1, 32'hA1B2C3D4, EN ? 32'hA1B2C3D4 : 32'h0,   !EN,    0,          EN ? 9 : 1,  0,   0,                           0,                    0);
        vecs[14] = mk("sb",      1, 3'd0, 32'h205,      32'h123456AB, 0, 0,            0,                           0,      1,          2,           1,   32'hAB,                      32'h205,              3'd0);
        vecs[15] = mk("lh_odd",  0, 3'd1, 32'h201,      0,            0, 0,            EN ? 32'h00000100 : 32'h0,   !EN,    0,          EN ? 5 : 1,  0,   0,                           0,                    0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Response held off for five cycles while a second request waits
        poke32(32'h300, 32'h11223344);
        poke32(32'h304, 32'h55667788);
        @(negedge clk);
        reqValid = 1'b1; reqAddr = 32'h300; reqOp = 3'd2; reqWe = 1'b0; rspReady = 1'b0;
        @(posedge clk);
        #1 reqAddr = 32'h304;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid && lat < 64);
        for (int i = 0; i < 5; i++) begin
            chk("hold rspValid", 32'(rspValid), 32'd1);
            chk("hold rspData",  rspData,       32'h11223344);
            chk("hold reqReady", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
        @(negedge clk);
        chk("b2b reqReady", 32'(reqReady), 32'd1);
        chk("b2b rspValid", 32'(rspValid), 32'd0);
        @(posedge clk);
        #1 reqValid = 1'b0; rspReady = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid && lat < 64);
        chk("b2b latency", 32'(lat), 32'd3);
        chk("b2b rspData", rspData, 32'h55667788);
        @(posedge clk);
        #1;

        // Reset asserted while a store beat is driving the memory
        rst_addr  = EN ? 32'h401 : 32'h400;
        rst_maddr = EN ? 32'h403 : 32'h400;
        rst_edges = EN ? 3 : 1;
        poke32(32'h400, 32'h0);
        poke32(32'h404, 32'h0);
        @(negedge clk);
        reqValid = 1'b1; reqAddr = rst_addr; reqWdata = 32'hA5B6C7D8; reqOp = 3'd2; reqWe = 1'b1;
        for (int i = 0; i < rst_edges; i++) begin
            @(posedge clk);
            #1 reqValid = 1'b0;
        end
        chk("pre-rst memWe",   32'(memWe), 32'd1);
        chk("pre-rst memAddr", memAddr,    rst_maddr);
        rst = 1'b1;
        #1;
        chk("mid-rst memWe",    32'(memWe),    32'd0);
        chk("mid-rst reqReady", 32'(reqReady), 32'd1);
        chk("mid-rst rspValid", 32'(rspValid), 32'd0);
        chk("mid-rst memAddr",  memAddr,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst-drop mem", peek(32'h400, 4), EN ? 32'h00C7D800 : 32'h0);
        chk("rst-drop mem hi", peek(32'h404, 1), 32'h0);
        chk("post-rst reqReady", 32'(reqReady), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_lsu_ctrl
`default_nettype wire
